// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the transmitter FSM encoding and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Integer floor: any fractional remainder is a small baud-rate error on the line.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO that feeds the UART transmitter.
// Full is reported from the stored count only, so a same-cycle pop never frees a slot early.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  output logic       full_o,
  input  logic       pop_i,
  output logic [7:0] pop_data_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count == CW'(DEPTH));
  assign empty_o    = (count == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of an 8N1 / 8E1 serializer.
// tx_o is registered from the next-state decode so it changes on the same edge as the FSM.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_EN   = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  // Valid/ready: a byte is taken on any rising edge with tx_valid_i && tx_ready_o;
  // the producer holds tx_data_i stable while valid is high and ready is low.

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  if (CPB < 4) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  uart_tx_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           bit_done;

  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (tx_valid_i),
    .push_data_i (tx_data_i),
    .full_o      (fifo_full),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .empty_o     (fifo_empty)
  );

  assign bit_done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          par_d    = even_parity(fifo_data);
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            par_d    = even_parity(fifo_data);
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = !fifo_full;
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one 8N1 and one 8E1 instance at 8 clocks per bit,
// with a line decoder checking every frame against the accepted-byte queues.
module tb_uart_tx;
  import uart_pkg::*;

  // 50 MHz / 6 MBd floors to 8 clocks per bit.
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 6_000_000;
  localparam int CPB    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data  [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       tx_line  [2];
  logic       busy     [2];
  logic [2:0] state    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(0), .FIFO_DEPTH(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .tx_o(tx_line[0]), .busy_o(busy[0]), .state_o(state[0])
  );

  uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1), .FIFO_DEPTH(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .tx_o(tx_line[1]), .busy_o(busy[1]), .state_o(state[1])
  );

  a_hold0: assert property (@(posedge clk) disable iff (rst)
    (tx_valid[0] && !tx_ready[0]) |=> (tx_valid[0] && $stable(tx_data[0])));
  a_hold1: assert property (@(posedge clk) disable iff (rst)
    (tx_valid[1] && !tx_ready[1]) |=> (tx_valid[1] && $stable(tx_data[1])));

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tx_valid[0] = 1'b0;
    tx_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic push(input int idx, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    tx_valid[idx] = 1'b1;
    tx_data[idx]  = d;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (tx_ready[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_timeout dut%0d: byte %02h never accepted", idx, d);
    end else if (idx == 0) exp_q0.push_back(d);
    else exp_q1.push_back(d);
    @(posedge clk); #1;
    tx_valid[idx] = 1'b0;
  endtask

  // Checks one full frame starting at the next edge, bit by bit and cycle by cycle.
  task automatic check_frame(input int idx, input logic [7:0] d);
    logic lv [11];
    int   nb;
    bit   err;
    nb = (idx == 1) ? 11 : 10;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[1 + i] = d[i];
    if (idx == 1) lv[9] = ^d;
    lv[nb - 1] = 1'b1;
    @(posedge clk);
    for (int b = 0; b < nb; b++) begin
      err = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (tx_line[idx] !== lv[b] || busy[idx] !== 1'b1) err = 1'b1;
      end
      total++;
      if (err) begin
        bad++;
        $display("FAIL frame_bit dut%0d byte %02h bit %0d: line=%b busy=%b, required line=%b busy=1 for %0d cycles",
                 idx, d, b, tx_line[idx], busy[idx], lv[b], CPB);
      end
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    total++;
    if (tx_line[idx] !== 1'b1 || busy[idx] !== 1'b0 || tx_ready[idx] !== 1'b1 || state[idx] !== IDLE) begin
      bad++;
      $display("FAIL %s dut%0d: tx=%b busy=%b ready=%b state=%0d, required tx=1 busy=0 ready=1 state=IDLE",
               tag, idx, tx_line[idx], busy[idx], tx_ready[idx], state[idx]);
    end
  endtask

  task automatic wait_idle(input int idx);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40000; t++) begin
      @(negedge clk);
      if (busy[idx] === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout dut%0d: busy still %b", idx, busy[idx]);
    end
    total++;
    if (((idx == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
      bad++;
      $display("FAIL missing_bytes dut%0d: %0d accepted bytes never decoded, required 0",
               idx, (idx == 0) ? exp_q0.size() : exp_q1.size());
    end
  endtask

  // ---------------- scoreboard: line decoder ----------------
  task automatic monitor(input int idx);
    int         k, b, nb;
    bit         in_frame;
    logic [7:0] d, e;
    logic       p;
    k = 0; in_frame = 1'b0; d = '0; p = 1'b0;
    nb = (idx == 1) ? 11 : 10;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame) begin
          if (tx_line[idx] === 1'b0) begin
            in_frame = 1'b1;
            k = 0;
          end
        end else begin
          k++;
        end
        if (in_frame && (k % CPB) == CPB / 2) begin
          b = k / CPB;
          if (b == 0) begin
            if (tx_line[idx] !== 1'b0) in_frame = 1'b0;
          end else if (b <= 8) begin
            d[b - 1] = tx_line[idx];
          end else if (b == 9 && nb == 11) begin
            p = tx_line[idx];
          end
          if (in_frame && b == nb - 1) begin
            in_frame = 1'b0;
            total++;
            if (tx_line[idx] !== 1'b1) begin
              bad++;
              $display("FAIL stop_bit dut%0d: got %b, required 1", idx, tx_line[idx]);
            end
            if (nb == 11) begin
              total++;
              if (p !== ^d) begin
                bad++;
                $display("FAIL parity dut%0d byte %02h: got %b, required %b", idx, d, p, ^d);
              end
            end
            total++;
            if (((idx == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
              bad++;
              $display("FAIL unexpected_byte dut%0d: decoded %02h with nothing accepted", idx, d);
            end else begin
              e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (d !== e) begin
                bad++;
                $display("FAIL decoded_byte dut%0d: got %02h, required %02h", idx, d, e);
              end
            end
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle(0, "reset_state");
    check_idle(1, "reset_state");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle(0, "post_reset_idle");
    check_idle(1, "post_reset_idle");
  endtask

  task automatic test_single();
    push(0, 8'h55);
    check_frame(0, 8'h55);
    @(negedge clk);
    check_idle(0, "busy_fall_after_frame");
    wait_idle(0);
  endtask

  task automatic test_parity();
    push(1, 8'h07);
    fork
      begin
        check_frame(1, 8'h07);
        check_frame(1, 8'h03);
      end
      push(1, 8'h03);
    join
    @(negedge clk);
    check_idle(1, "parity_busy_fall");
    wait_idle(1);
  endtask

  task automatic test_back_to_back();
    push(0, 8'h41);
    fork
      begin
        check_frame(0, 8'h41);
        check_frame(0, 8'h42);
      end
      push(0, 8'h42);
    join
    @(negedge clk);
    check_idle(0, "b2b_busy_fall");
    wait_idle(0);
  endtask

  task automatic test_fill();
    logic [7:0] b [20];
    int accepted, drop_at, rise, acc0_edge;
    bit dropped;
    accepted = 0; drop_at = -1; rise = -1; acc0_edge = 0; dropped = 1'b0;
    for (int i = 0; i < 20; i++) b[i] = 8'($urandom);
    do_reset();
    tx_valid[0] = 1'b1;
    tx_data[0]  = b[0];
    for (int t = 0; t < 4000 && accepted < 20; t++) begin
      @(negedge clk);
      if (tx_ready[0] === 1'b1) begin
        if (dropped && rise < 0) rise = cyc;
        if (accepted == 0) acc0_edge = cyc + 1;
        exp_q0.push_back(b[accepted]);
        accepted++;
        @(posedge clk); #1;
        if (accepted < 20) tx_data[0] = b[accepted];
        else tx_valid[0] = 1'b0;
      end else if (!dropped) begin
        dropped = 1'b1;
        drop_at = accepted;
      end
    end
    tx_valid[0] = 1'b0;
    total++;
    if (accepted != 20) begin
      bad++;
      $display("FAIL fill_accept_all: accepted %0d, required 20", accepted);
    end
    total++;
    if (drop_at != 17) begin
      bad++;
      $display("FAIL fill_count_at_full: accepted %0d before ready dropped, required 17", drop_at);
    end
    total++;
    if (rise != acc0_edge + 1 + 10 * CPB) begin
      bad++;
      $display("FAIL fill_ready_rise: ready rose after edge %0d, required %0d", rise, acc0_edge + 1 + 10 * CPB);
    end
    wait_idle(0);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [7:0] b0;
    b0 = 8'($urandom);
    push(0, b0);
    n = cyc;
    for (int i = 0; i < 4; i++) push(0, 8'($urandom));
    while (cyc < n + 1 + 4 * CPB + CPB / 2) @(posedge clk);
    @(negedge clk);
    total++;
    if (state[0] !== DATA || tx_line[0] !== b0[3]) begin
      bad++;
      $display("FAIL pre_reset_bit3: state=%0d tx=%b, required state=DATA tx=%b", state[0], tx_line[0], b0[3]);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    check_idle(0, "reset_mid_frame");
    push(0, 8'hA5);
    check_frame(0, 8'hA5);
    wait_idle(0);
  endtask

  task automatic test_random();
    fork
      for (int i = 0; i < 200; i++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        push(0, 8'($urandom));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        push(1, 8'($urandom));
      end
    join
    wait_idle(0);
    wait_idle(1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    tx_data[0]  = 8'h00; tx_data[1]  = 8'h00;
    fork
      monitor(0);
      monitor(1);
    join_none
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_fill();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
